// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Round-robin arbiter for N requesters that share one tristate bus.
//   Each ownership period follows IDLE -> GNT -> DRV -> TURN -> IDLE.
//   In GNT the owner is told it has the bus, but its driver stays disabled.
//   In DRV the owner's tristate driver is enabled.
//   TURN is one dead cycle with every driver disabled, so two drivers are
//   never enabled at the same time.
//   All outputs are registered. Each output is computed from the next state
//   and loaded on the same edge as the state register, so the outputs always
//   match the state the FSM is in.
//
// Handshake: req is a level signal that is held until the requester has been
//   granted and has finished. done is a release strobe. Only the current
//   owner's req and done bits are looked at, and only while in DRV.
//   Outside IDLE, the req and done bits of all other requesters are ignored.
//   An owner leaves DRV when it raises done, drops req, or uses up HOLD_MAX
//   cycles. If the grant runs out while the owner still wants the bus,
//   timeout pulses during the TURN cycle.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req[N]     per-requester bus request (level)
//   done[N]    per-requester release (only the owner's bit is used)
//   grant[N]   one-hot ownership, high in GNT and DRV
//   drv_en[N]  one-hot tristate enable, high in DRV only
//   owner[3]   binary index of the owner, 0 when there is no owner
//   bus_idle   high only in IDLE
//   timeout    one-cycle pulse when HOLD_MAX revokes a grant
//   dbg_state  current FSM state encoding (0 IDLE, 1 GNT, 2 DRV, 3 TURN)
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic [N-1:0] drv_en,
  output logic [2:0]   owner,
  output logic         bus_idle,
  output logic         timeout,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT  = 2'd1,
    S_DRV  = 2'd2,
    S_TURN = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
  localparam logic [2:0] LAST_RST   = 3'(N-1);
  localparam logic [3:0] N_C        = 4'(N);

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   drv_en_q, drv_en_d;
  logic [2:0]     owner_q, owner_d;
  logic           bus_idle_q, bus_idle_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     hold_q, hold_d;
  logic [2:0]     last_owner_q, last_owner_d;

  // Widened copies let the FSM index with the full 3-bit owner for any N.
  logic [7:0]     req_ext, done_ext, owner_oh;
  logic [3:0]     idx;
  logic [2:0]     winner;
  logic           found;
  logic           own_done, own_req, hold_at_max;

  always_comb begin
    req_ext  = '0;
    done_ext = '0;
    req_ext[N-1:0]  = req;
    done_ext[N-1:0] = done;
  end

  // Round-robin search. It starts one past last_owner and wraps upward.
  // Because last_owner resets to N-1, index 0 wins the first arbitration.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, last_owner_q} + 4'(i);
      if (idx >= N_C) idx = idx - N_C;
      if (!found && req_ext[idx[2:0]]) begin
        winner = idx[2:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    drv_en_d     = drv_en_q;
    owner_d      = owner_q;
    timeout_d    = 1'b0;
    hold_d       = hold_q;
    last_owner_d = last_owner_q;
    owner_oh     = 8'd1 << owner_q;
    own_done     = done_ext[owner_q];
    own_req      = req_ext[owner_q];
    hold_at_max  = (hold_q == HOLD_MAX_C);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_GNT;
          owner_d  = winner;
          owner_oh = 8'd1 << winner;
          grant_d  = owner_oh[N-1:0];
          drv_en_d = '0;
          hold_d   = 8'd0;
        end
      end
      S_GNT: begin
        // The owner always gets at least one DRV cycle, even if it dropped
        // req during GNT.
        state_d  = S_DRV;
        drv_en_d = owner_oh[N-1:0];
        hold_d   = 8'd1;
      end
      S_DRV: begin
        if (own_done || !own_req || hold_at_max) begin
          state_d      = S_TURN;
          grant_d      = '0;
          drv_en_d     = '0;
          owner_d      = '0;
          last_owner_d = owner_q;
          // If done arrives on the same cycle the limit is reached, it counts
          // as a normal release, so no timeout pulse.
          timeout_d    = hold_at_max && !own_done && own_req;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        drv_en_d = '0;
        owner_d  = '0;
      end
    endcase

    bus_idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      drv_en_q     <= '0;
      owner_q      <= '0;
      bus_idle_q   <= 1'b1;
      timeout_q    <= 1'b0;
      hold_q       <= 8'd0;
      last_owner_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      drv_en_q     <= drv_en_d;
      owner_q      <= owner_d;
      bus_idle_q   <= bus_idle_d;
      timeout_q    <= timeout_d;
      hold_q       <= hold_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant     = grant_q;
  assign drv_en    = drv_en_q;
  assign owner     = owner_q;
  assign bus_idle  = bus_idle_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
